// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signal bundle between the AHB fabric and its arbiter.
// "master" is the requesting/bus side; "slave" is the arbiter side that returns grant and ownership.
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic [1:0]             htrans;
   logic [2:0]             hburst;
   logic                   hready;
   logic [1:0]             hresp;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [3:0]             hmaster;
   logic                   hmastlock;

   modport master (
      output hbusreq, hlock, htrans, hburst, hready, hresp,
      input  hgrant, hmaster, hmastlock
   );

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready, hresp,
      output hgrant, hmaster, hmastlock
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter: registered one-hot hgrant, hmaster, hmastlock; a decision lands one hclk after an hready=1 edge, everything holds while hready=0.
// Define ARB_ROUND_ROBIN_EN for round-robin search after the last winner; otherwise fixed priority, lowest index first.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input logic              hclk,
   input logic              hreset,
   ahb_bus_arbiter_if.slave bus
);
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IW-1:0]          DEF_IDX   = IW'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

   typedef enum logic [1:0] {ARB, BURST, LOCK, LOCK_LAST} state_t;

   state_t                 state, state_next;
   logic [4:0]             cnt, cnt_next, burst_len;
   logic [IW-1:0]          grant_idx, win_idx;
   logic [NUM_MASTERS-1:0] grant_q, grant_next;
   logic [3:0]             master_q;
   logic                   lock_q, mastlock_next;
   logic                   acc, err, decide, lock_win;

   assign acc = bus.hready & bus.htrans[1];
   // Only the first, wait-stated cycle of a two-cycle non-OKAY response aborts.
   assign err = (bus.hresp != 2'd0) & ~bus.hready;

   always_comb begin
      case (bus.hburst)
         3'd2, 3'd3: burst_len = 5'd3;
         3'd4, 3'd5: burst_len = 5'd7;
         3'd6, 3'd7: burst_len = 5'd15;
         default:    burst_len = 5'd0;
      endcase
   end

   always_comb begin
      cnt_next = cnt;
      if (err)
         cnt_next = 5'd0;
      else if (acc && !bus.htrans[0])
         cnt_next = burst_len;
      else if (acc && bus.htrans[0] && cnt != 5'd0)
         cnt_next = cnt - 5'd1;
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic [IW-1:0] rr_ptr;
   logic [4:0]    cand;

   // Walk from the farthest candidate inwards so the nearest requester after rr_ptr wins.
   always_comb begin
      win_idx = DEF_IDX;
      cand    = 5'd0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         cand = 5'(rr_ptr) + 5'(k);
         if (cand >= 5'(NUM_MASTERS))
            cand = cand - 5'(NUM_MASTERS);
         if (bus.hbusreq[IW'(cand)])
            win_idx = IW'(cand);
      end
   end

   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset)
         rr_ptr <= DEF_IDX;
      else if (decide && win_idx != grant_idx)
         rr_ptr <= win_idx;
   end
`else
   always_comb begin
      win_idx = DEF_IDX;
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
         if (bus.hbusreq[i])
            win_idx = IW'(i);
   end
`endif

   assign lock_win   = bus.hlock[win_idx] & bus.hbusreq[win_idx];
   assign grant_next = NUM_MASTERS'(1) << win_idx;

   always_comb begin
      state_next = state;
      decide     = 1'b0;
      if (err) begin
         state_next = (state == LOCK || state == LOCK_LAST) ? LOCK_LAST : ARB;
      end else if (bus.hready) begin
         case (state)
            ARB, BURST: begin
               if (cnt_next > 5'd1) begin
                  state_next = BURST;
               end else begin
                  decide     = 1'b1;
                  state_next = lock_win ? LOCK : ARB;
               end
            end
            LOCK: begin
               if (!bus.hlock[grant_idx])
                  state_next = LOCK_LAST;
            end
            LOCK_LAST: begin
               if (acc) begin
                  if (cnt_next > 5'd1) begin
                     state_next = BURST;
                  end else begin
                     decide     = 1'b1;
                     state_next = lock_win ? LOCK : ARB;
                  end
               end
            end
            default: state_next = ARB;
         endcase
      end
   end

   assign mastlock_next = bus.hlock[grant_idx] & ((state == LOCK) | (state_next == LOCK));

   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         state     <= ARB;
         cnt       <= 5'd0;
         grant_idx <= DEF_IDX;
         grant_q   <= GRANT_RST;
         master_q  <= 4'(DEFAULT_MASTER);
         lock_q    <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (decide) begin
            grant_idx <= win_idx;
            grant_q   <= grant_next;
         end
         // Address-phase ownership follows the grant that was visible before this edge.
         if (bus.hready) begin
            master_q <= 4'(grant_idx);
            lock_q   <= mastlock_next;
         end
      end
   end

   assign bus.hgrant    = grant_q;
   assign bus.hmaster   = master_q;
   assign bus.hmastlock = lock_q;
endmodule
